// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
// The checksum state is only reachable when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int         BYTE_W     = 8;
   localparam int         WORD_W     = 2 * BYTE_W;
   localparam int         CNT_W      = 8;
   localparam logic [7:0] NOP_OPCODE = 8'd47;

endpackage

// File: rtl/loader_csum.sv
// Running 8-bit byte sum with clear/add and an equality compare.
// Instantiated by instr_loader only when LOADER_CHECKSUM_EN is defined.
module loader_csum #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         add_i,
   input  logic [W-1:0] data_i,
   input  logic [W-1:0] cmp_i,
   output logic         match_o
);

   logic [W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (add_i) begin
         sum_d = sum_q + data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/instr_loader.sv
// Length-prefixed byte stream to 16-bit instruction memory writes.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for the length byte N
// LO      | waiting for the even-address (low) byte of a pair
// HI      | waiting for the odd-address (high) byte of a pair
// CSUM    | waiting for the checksum byte (checksum build only)
// DONE    | load complete, done held until restart
// ERR     | checksum mismatch, err held until restart
module instr_loader
   import loader_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = DATA_WIDTH'(NOP_OPCODE)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic                    rx_valid,
   input  logic                    restart,
   output logic                    we,
   output logic [2*DATA_WIDTH-1:0] w_instr,
   output logic [ADDR_WIDTH-1:0]   w_addr,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        n_q, n_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        cnt_inc;
   logic [CNT_W-1:0]        rx_len;
   logic [DATA_WIDTH-1:0]   lo_q, lo_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [2*DATA_WIDTH-1:0] w_instr_q, w_instr_d;
   logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   state_e                  st_after_data;

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign rx_len  = CNT_W'(rx_data);

`ifdef LOADER_CHECKSUM_EN
   logic err_q, err_d;
   logic csum_clr, csum_add, csum_match;

   assign st_after_data = ST_CSUM;

   loader_csum #(.W(DATA_WIDTH)) u_csum (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (csum_clr),
      .add_i   (csum_add),
      .data_i  (rx_data),
      .cmp_i   (rx_data),
      .match_o (csum_match)
   );
`else
   assign st_after_data = ST_DONE;
`endif

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      addr_d    = addr_q;
      we_d      = 1'b0;
      w_instr_d = w_instr_q;
      w_addr_d  = w_addr_q;
      busy_d    = busy_q;
      done_d    = done_q;
`ifdef LOADER_CHECKSUM_EN
      err_d     = err_q;
      csum_clr  = 1'b0;
      csum_add  = 1'b0;
`endif
      if (restart) begin
         // Dropping back to IDLE here also discards any byte in this cycle.
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
         err_d   = 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_valid) begin
                  n_d    = rx_len;
                  cnt_d  = '0;
                  addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
                  csum_clr = 1'b1;
`endif
                  if (rx_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     state_d = ST_CSUM;
`else
                     state_d = ST_DONE;
                     done_d  = 1'b1;
`endif
                  end else begin
                     state_d = ST_LO;
                     busy_d  = 1'b1;
                  end
               end
            end
            ST_LO: begin
               if (rx_valid) begin
                  lo_d  = rx_data;
                  cnt_d = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
                  csum_add = 1'b1;
`endif
                  if (cnt_inc == n_q) begin
                     we_d      = 1'b1;
                     w_instr_d = {PAD_BYTE, rx_data};
                     w_addr_d  = addr_q;
                     addr_d    = addr_q + ADDR_WIDTH'(2);
                     state_d   = st_after_data;
                  end else begin
                     state_d = ST_HI;
                  end
               end
            end
            ST_HI: begin
               if (rx_valid) begin
                  cnt_d     = cnt_inc;
                  we_d      = 1'b1;
                  w_instr_d = {rx_data, lo_q};
                  w_addr_d  = addr_q;
                  addr_d    = addr_q + ADDR_WIDTH'(2);
`ifdef LOADER_CHECKSUM_EN
                  csum_add = 1'b1;
`endif
                  state_d = (cnt_inc == n_q) ? st_after_data : ST_LO;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (rx_valid) begin
                  busy_d = 1'b0;
                  if (csum_match) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end
               end
            end
            ST_ERR: begin
               err_d  = 1'b1;
               busy_d = 1'b0;
            end
`endif
            ST_DONE: begin
               // Without checksum, done lands one cycle after the final write.
               done_d = 1'b1;
               busy_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         cnt_q     <= '0;
         lo_q      <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         w_instr_q <= '0;
         w_addr_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         lo_q      <= lo_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         w_instr_q <= w_instr_d;
         w_addr_q  <= w_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign we      = we_q;
   assign w_instr = w_instr_q;
   assign w_addr  = w_addr_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed streams plus random streams
// checked against a list-based model of the expected writes and completion.
module tb_instr_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        restart;
   logic        we;
   logic [15:0] w_instr;
   logic [7:0]  w_addr;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0]  wq_addr[$];
   logic [15:0] wq_word[$];
   int          wq_cyc[$];
   int          done_cyc;
   int          err_cyc;
   bit          busy_seen;

   logic [7:0]  dat[$];
   logic [7:0]  tx[$];
   int          samp[$];

   instr_loader dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .restart  (restart),
      .we       (we),
      .w_instr  (w_instr),
      .w_addr   (w_addr),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Output observer, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (we === 1'b1) begin
            wq_addr.push_back(w_addr);
            wq_word.push_back(w_instr);
            wq_cyc.push_back(cyc);
         end
         if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
         if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
         if (busy === 1'b1) busy_seen = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      wq_addr.delete();
      wq_word.delete();
      wq_cyc.delete();
      done_cyc  = -1;
      err_cyc   = -1;
      busy_seen = 1'b0;
   endtask

   task automatic restart_dut();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      clear_obs();
   endtask

   task automatic send_tx(input int max_gap);
      int g;
      samp.delete();
      foreach (tx[i]) begin
         g = $urandom_range(0, max_gap);
         repeat (g) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
         end
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = tx[i];
         samp.push_back(cyc + 1);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Sends length + dat (+ checksum) and compares against the expected write list.
   task automatic run_stream(input int max_gap, input bit bad);
      int n, npairs, last, exp_done, exp_err;
      logic [7:0] sum, hi;
      restart_dut();
      n = dat.size();
      tx.delete();
      tx.push_back(8'(n));
      sum = 8'h00;
      foreach (dat[i]) begin
         tx.push_back(dat[i]);
         sum = sum + dat[i];
      end
`ifdef LOADER_CHECKSUM_EN
      tx.push_back(bad ? sum + 8'h01 : sum);
`endif
      send_tx(max_gap);
      repeat (4) @(negedge clk);
      npairs = (n + 1) / 2;
      chk("wr_count", wq_addr.size(), npairs);
      for (int k = 0; k < npairs && k < wq_addr.size(); k++) begin
         hi   = (2*k + 1 < n) ? dat[2*k + 1] : 8'h2F;
         last = (2*k + 1 < n) ? 2*k + 1 : 2*k;
         chk("wr_addr", wq_addr[k], 2*k);
         chk("wr_word", wq_word[k], {hi, dat[2*k]});
         chk("wr_cycle", wq_cyc[k], samp[last + 1]);
      end
`ifdef LOADER_CHECKSUM_EN
      exp_done = bad ? -1 : samp[n + 1];
      exp_err  = bad ? samp[n + 1] : -1;
`else
      exp_done = (n == 0) ? samp[0] : samp[n] + 1;
      exp_err  = -1;
`endif
      chk("done_cycle", done_cyc, exp_done);
      chk("err_cycle", err_cyc, exp_err);
      chk("busy_seen", busy_seen, n > 0);
      chk("busy_end", busy, 1'b0);
   endtask

   initial begin
      rst      = 1'b1;
      restart  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      clear_obs();
      repeat (2) @(negedge clk);
      chk("rst_we", we, 1'b0);
      chk("rst_instr", w_instr, 16'h0000);
      chk("rst_addr", w_addr, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;

      dat = '{8'h18, 8'h00, 8'h09, 8'h1A};
      run_stream(0, 1'b0);
      dat = '{8'h00, 8'h05, 8'h1C};
      run_stream(0, 1'b0);
      dat.delete();
      run_stream(0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      dat = '{8'h0A, 8'h0B};
      run_stream(0, 1'b0);
      run_stream(0, 1'b1);
`endif

      // restart together with the fourth data byte drops that pair
      restart_dut();
      tx = '{8'h04, 8'h01, 8'h02, 8'h03};
      send_tx(0);
      rx_valid = 1'b1;
      rx_data  = 8'h04;
      restart  = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      restart  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rs_count", wq_addr.size(), 1);
      if (wq_addr.size() > 0) begin
         chk("rs_addr", wq_addr[0], 8'h00);
         chk("rs_word", wq_word[0], 16'h0201);
      end
      chk("rs_done", done_cyc, -1);
      chk("rs_busy", busy, 1'b0);
      dat = '{8'h07, 8'h08};
      run_stream(0, 1'b0);

      // asynchronous reset while waiting for a high byte
      restart_dut();
      tx = '{8'h04, 8'h11};
      send_tx(0);
      #1 rst = 1'b1;
      #1;
      chk("ar_we", we, 1'b0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_addr", w_addr, 8'h00);
      chk("ar_instr", w_instr, 16'h0000);
      chk("ar_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("ar_nowrite", wq_addr.size(), 0);
      dat = '{8'hAA, 8'hBB};
      run_stream(1, 1'b0);

      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(1, 30);
         dat.delete();
         for (int i = 0; i < n; i++) dat.push_back(8'($urandom));
         run_stream(2, 1'($urandom_range(0, 1)));
      end

      dat.delete();
      for (int i = 0; i < 255; i++) dat.push_back(8'($urandom));
      run_stream(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream program loader that sits directly upstream of the instruction memory write port. It accepts a length-prefixed stream of instruction bytes from a serial front end (e.g. a UART receiver), and packs consecutive byte pairs into 16-bit write words. It issues one write strobe per pair at even byte addresses starting from 0, then signals completion so the cores can be released.

## Interface
- `DATA_WIDTH`, 8: instruction byte width; the write word is 2*DATA_WIDTH.
- `ADDR_WIDTH`, 8: byte address width of the instruction memory.
- `PAD_BYTE`, 8'd47: high byte written when the length is odd (NOP opcode).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  DATA_WIDTH  incoming byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `restart`  in  1  one-cycle pulse; aborts the load or leaves DONE/ERR and returns to IDLE.
- `we`  out  1  write strobe to instruction memory, one cycle per pair.
- `w_instr`  out  2*DATA_WIDTH  write word: [7:0] = even-address byte, [15:8] = odd-address byte.
- `w_addr`  out  ADDR_WIDTH  even byte address of the pair.
- `busy`  out  1  a load is in progress.
- `done`  out  1  load completed successfully; held until `restart` or `rst`.
- `err`  out  1  checksum mismatch; held until `restart` or `rst`. Driven 0 when the checksum feature is compiled out.

## Operation
- States: IDLE, LO, HI, CSUM (compiled in only), DONE, ERR.
- **IDLE**
  - The first accepted byte is N, the instruction byte count (0..255).
  - N=0: go to DONE, or CSUM when the checksum is compiled in.
  - N>0: go to LO and clear the byte counter and the address to 0.
- **LO**
  - Latch the byte as the pair's low byte and increment the byte counter.
  - If this was the last byte (odd N): issue a write with high byte = PAD_BYTE, then go to CSUM or DONE.
  - Otherwise go to HI.
- **HI**
  - Latch the high byte and issue a write at `w_addr`.
  - After the write, `w_addr` advances by 2.
  - If the count has reached N: go to CSUM or DONE. Otherwise return to LO.
- Arithmetic rules:
  - The address wraps modulo 2^ADDR_WIDTH. With N ≤ 255 the highest pair address is 254, so wrap is never reached in normal use.
  - The byte counter is 8 bits and compares against N.
- Bytes received in DONE or ERR are ignored.
- Boundary conditions:
  - `restart` mid-load: return to IDLE immediately. The pending write is not issued. Bytes already written stay in memory.
  - `restart` and `rx_valid` in the same cycle: `restart` wins and the byte is dropped.
  - `rst` mid-load: all state and outputs clear asynchronously.
- Reset values: `we`=0, `w_instr`=0, `w_addr`=0, `busy`=0, `done`=0, `err`=0, state=IDLE.

## Timing
- `we` is registered. It is high for exactly one cycle: the cycle after the `rx_valid` carrying the high byte, or after the last low byte when N is odd.
- `w_instr` and `w_addr` are stable in every cycle in which `we` is high.
- Back-to-back `rx_valid` on every cycle is sustained with no stalls; there is no backpressure.
- `busy` rises the cycle after the length byte (N>0) and falls when `done` or `err` rises.
- Without checksum: `done` rises the cycle after the final `we`. With N=0, it rises the cycle after the length byte.
- With checksum: `done` or `err` rises the cycle after the checksum byte's `rx_valid`. The checksum byte may arrive in the same cycle that the final `we` is high.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the N data bytes, exactly one extra byte is expected.
  - It is compared with the 8-bit sum modulo 256 of the N instruction bytes. The length byte and the pad byte are excluded from the sum.
  - Match → DONE. Mismatch → ERR (`err`=1, `done`=0).
- Undefined:
  - No CSUM state and no trailing byte.
  - `err` is tied to 0.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum;
  - the NOP opcode value (47) used as the `PAD_BYTE` default;
  - the write-word width constant.
- Sub-module `loader_csum` (8-bit accumulator with clear/add/compare) is instantiated only under `LOADER_CHECKSUM_EN`.

## Test plan
- Stream 04,18,00,09,1A, back-to-back, no checksum → `we` at addr 0 with w_instr=0x0018, then addr 2 with 0x1A09; `done`=1 one cycle after the second `we`.
- Stream 03,00,05,1C (odd N) → writes 0x0500 @0, then 0x2F1C @2 (pad 0x2F); `done` follows.
- Stream 00 → no `we`; `done`=1 the next cycle; `busy` never rises.
- Checksum build: stream 02,0A,0B,15 → `done`=1. Stream 02,0A,0B,16 → `err`=1, `done`=0.
- Send 04,01,02,03, then pulse `restart` together with the fourth data byte → one write only (0x0201 @0), return to IDLE. A fresh stream 02,07,08 then writes 0x0807 @0.
- Assert `rst` while in HI → all outputs 0 next observation, no `we`. Bytes sent after reset are interpreted starting from the length byte.
